// File: rtl/redirect_ctrl_pkg.sv
// Shared pipeline types for the PC redirect sequencer: redirect state
// encoding and the request bundle used by both decode and the late stage.
package redirect_ctrl_pkg;

  typedef logic        u1;
  typedef logic [63:0] u64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    PEND  = 2'd2
  } redirect_state_t;

  typedef struct packed {
    u1  valid;
    u64 target;
  } redirect_t;

endpackage

// File: rtl/redirect_arb.sv
// Priority select between the late-stage (trap/mret) redirect and the
// decode-stage redirect. The late stage always wins because it kills
// everything younger, including the decode instruction.
module redirect_arb
  import redirect_ctrl_pkg::*;
(
  input  redirect_t x_req,
  input  redirect_t d_req,
  output redirect_t sel_req
);

  // Late-stage request overrides decode; target follows the winner.
  always_comb begin
    sel_req.valid  = x_req.valid | d_req.valid;
    sel_req.target = x_req.valid ? x_req.target : d_req.target;
  end

endmodule

// File: rtl/redirect_ctrl.sv
// PC redirect sequencer. Squashes IF/ID on a redirect, waits out and
// discards an in-flight ibus fetch, and holds the redirect on the PC mux
// until the PC register takes it. Also counts applied redirects and
// discarded fetch responses.
module redirect_ctrl
  import redirect_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_redirect,
  input  logic [63:0]      d_target,
  input  logic             d_fire,
  input  logic             x_redirect,
  input  logic [63:0]      x_target,
  input  logic             f_busy,
  input  logic             f_done,
  input  logic             pc_ready,
  output logic             pc_sel,
  output logic [63:0]      pc_target,
  output logic             flush_f,
  output logic             drop_resp,
  output logic             stall_f,
  output logic             busy,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  redirect_state_t  state, state_n;
  u64               tgt, tgt_n;
  u64               eff_target;
  logic [CNT_W-1:0] redirect_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;
  redirect_t        d_req;
  redirect_t        x_req;
  redirect_t        sel_req;

  // Decode redirects only count in IDLE; outside IDLE decode holds bubbles.
  always_comb begin
    d_req.valid  = d_redirect & d_fire & (state == IDLE);
    d_req.target = d_target;
    x_req.valid  = x_redirect;
    x_req.target = x_target;
  end

  redirect_arb u_arb (
    .x_req   (x_req),
    .d_req   (d_req),
    .sel_req (sel_req)
  );

  // While a redirect is parked, a newer late-stage redirect replaces it.
  assign eff_target = x_redirect ? x_target : tgt;

  // Next-state and output decode; everything is forced low during reset.
  always_comb begin
    state_n   = state;
    tgt_n     = tgt;
    pc_sel    = 1'b0;
    pc_target = '0;
    flush_f   = 1'b0;
    drop_resp = 1'b0;
    stall_f   = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (sel_req.valid) begin
            flush_f = 1'b1;
            if (f_busy && !f_done) begin
              stall_f = 1'b1;
              tgt_n   = sel_req.target;
              state_n = DRAIN;
            end else begin
              drop_resp = f_done;
              pc_sel    = 1'b1;
              pc_target = sel_req.target;
              if (!pc_ready) begin
                tgt_n   = sel_req.target;
                state_n = PEND;
              end
            end
          end
        end
        DRAIN: begin
          stall_f = 1'b1;
          flush_f = 1'b1;
          tgt_n   = eff_target;
          if (f_done) begin
            drop_resp = 1'b1;
            pc_sel    = 1'b1;
            pc_target = eff_target;
            state_n   = pc_ready ? IDLE : PEND;
          end
        end
        PEND: begin
          pc_sel    = 1'b1;
          flush_f   = 1'b1;
          stall_f   = 1'b1;
          pc_target = eff_target;
          tgt_n     = eff_target;
          if (pc_ready) begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State, parked target and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      tgt            <= '0;
      redirect_cnt_q <= '0;
      drop_cnt_q     <= '0;
    end else begin
      state <= state_n;
      tgt   <= tgt_n;
      if (pc_sel && pc_ready) begin
        redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
      end
      if (drop_resp) begin
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  assign busy         = ~reset & (state != IDLE);
  assign redirect_cnt = reset ? '0 : redirect_cnt_q;
  assign drop_cnt     = reset ? '0 : drop_cnt_q;

  // Fetch is stalled in PEND, so an ibus response there breaks the contract.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(state == PEND && f_done));
    end
  end

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed self-checking bench for redirect_ctrl: each step drives inputs,
// pushes the expected outputs to a scoreboard and pops/compares them.
module tb_redirect_ctrl;

  localparam int CNT_W = 32;

  logic             clk;
  logic             reset;
  logic             d_redirect;
  logic [63:0]      d_target;
  logic             d_fire;
  logic             x_redirect;
  logic [63:0]      x_target;
  logic             f_busy;
  logic             f_done;
  logic             pc_ready;
  logic             pc_sel;
  logic [63:0]      pc_target;
  logic             flush_f;
  logic             drop_resp;
  logic             stall_f;
  logic             busy;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] drop_cnt;

  typedef struct {
    logic             sel;
    logic [63:0]      tgt;
    logic             flush;
    logic             drop;
    logic             stall;
    logic             busy;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] dcnt;
  } exp_t;

  exp_t             sb[$];
  int               checks;
  int               errors;
  logic [CNT_W-1:0] exp_rcnt;
  logic [CNT_W-1:0] exp_dcnt;

  redirect_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .d_redirect   (d_redirect),
    .d_target     (d_target),
    .d_fire       (d_fire),
    .x_redirect   (x_redirect),
    .x_target     (x_target),
    .f_busy       (f_busy),
    .f_done       (f_done),
    .pc_ready     (pc_ready),
    .pc_sel       (pc_sel),
    .pc_target    (pc_target),
    .flush_f      (flush_f),
    .drop_resp    (drop_resp),
    .stall_f      (stall_f),
    .busy         (busy),
    .redirect_cnt (redirect_cnt),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOne(input string tag, input string name,
                          input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, name, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.scoreboard: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      checkOne(tag, "pc_sel",       {63'd0, pc_sel},    {63'd0, e.sel});
      checkOne(tag, "pc_target",    pc_target,          e.tgt);
      checkOne(tag, "flush_f",      {63'd0, flush_f},   {63'd0, e.flush});
      checkOne(tag, "drop_resp",    {63'd0, drop_resp}, {63'd0, e.drop});
      checkOne(tag, "stall_f",      {63'd0, stall_f},   {63'd0, e.stall});
      checkOne(tag, "busy",         {63'd0, busy},      {63'd0, e.busy});
      checkOne(tag, "redirect_cnt", 64'(redirect_cnt),  64'(e.rcnt));
      checkOne(tag, "drop_cnt",     64'(drop_cnt),      64'(e.dcnt));
    end
  endtask

  // One clock step: drive inputs at the falling edge, record expectations,
  // compare shortly after, then advance the bench's counter model.
  task automatic applyStimulus(
    input string tag, input logic rst,
    input logic dr, input logic df, input logic [63:0] dt,
    input logic xr, input logic [63:0] xt,
    input logic fb, input logic fd, input logic rdy,
    input logic e_sel, input logic [63:0] e_tgt, input logic e_flush,
    input logic e_drop, input logic e_stall, input logic e_busy);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    d_redirect = dr;
    d_fire     = df;
    d_target   = dt;
    x_redirect = xr;
    x_target   = xt;
    f_busy     = fb;
    f_done     = fd;
    pc_ready   = rdy;
    e.sel   = e_sel;
    e.tgt   = e_tgt;
    e.flush = e_flush;
    e.drop  = e_drop;
    e.stall = e_stall;
    e.busy  = e_busy;
    e.rcnt  = rst ? '0 : exp_rcnt;
    e.dcnt  = rst ? '0 : exp_dcnt;
    sb.push_back(e);
    #1;
    checkOutput(tag);
    if (rst) begin
      exp_rcnt = '0;
      exp_dcnt = '0;
    end else begin
      if (e_sel && rdy) exp_rcnt = exp_rcnt + 1'b1;
      if (e_drop)       exp_dcnt = exp_dcnt + 1'b1;
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_rcnt = '0;
    exp_dcnt = '0;
    reset      = 1'b1;
    d_redirect = 1'b0;
    d_fire     = 1'b0;
    d_target   = '0;
    x_redirect = 1'b0;
    x_target   = '0;
    f_busy     = 1'b0;
    f_done     = 1'b0;
    pc_ready   = 1'b0;

    // Reset: outputs low even with redirect inputs active
    applyStimulus("rst0", 1, 1, 1, 64'h1234, 1, 64'h5678, 0, 1, 1,  0, 64'h0, 0, 0, 0, 0);
    applyStimulus("rst1", 1, 0, 0, 64'h0, 0, 64'h0, 0, 0, 0,        0, 64'h0, 0, 0, 0, 0);
    applyStimulus("idle", 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 1,        0, 64'h0, 0, 0, 0, 0);

    // Zero-latency decode redirect
    applyStimulus("t1acc", 0, 1, 1, 64'h8000_0040, 0, 64'h0, 0, 0, 1, 1, 64'h8000_0040, 1, 0, 0, 0);
    applyStimulus("t1aft", 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 1,        0, 64'h0, 0, 0, 0, 0);
    // d_redirect without d_fire is not accepted
    applyStimulus("t1nof", 0, 1, 0, 64'h777, 0, 64'h0, 0, 0, 1,      0, 64'h0, 0, 0, 0, 0);

    // Drain an outstanding fetch, then redirect on the response cycle
    applyStimulus("t2acc", 0, 1, 1, 64'h100, 0, 64'h0, 1, 0, 1,      0, 64'h0, 1, 0, 1, 0);
    applyStimulus("t2dr1", 0, 0, 0, 64'h0, 0, 64'h0, 1, 0, 1,        0, 64'h0, 1, 0, 1, 1);
    applyStimulus("t2dr2", 0, 1, 1, 64'h999, 0, 64'h0, 1, 0, 1,      0, 64'h0, 1, 0, 1, 1);
    applyStimulus("t2dr3", 0, 0, 0, 64'h0, 0, 64'h0, 1, 0, 1,        0, 64'h0, 1, 0, 1, 1);
    applyStimulus("t2don", 0, 0, 0, 64'h0, 0, 64'h0, 1, 1, 1,        1, 64'h100, 1, 1, 1, 1);
    applyStimulus("t2aft", 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 1,        0, 64'h0, 0, 0, 0, 0);

    // Late-stage redirect during drain replaces the parked target
    applyStimulus("t3acc", 0, 1, 1, 64'h100, 0, 64'h0, 1, 0, 1,      0, 64'h0, 1, 0, 1, 0);
    applyStimulus("t3dr1", 0, 0, 0, 64'h0, 0, 64'h0, 1, 0, 1,        0, 64'h0, 1, 0, 1, 1);
    applyStimulus("t3xr",  0, 0, 0, 64'h0, 1, 64'h8000_0004, 1, 0, 1, 0, 64'h0, 1, 0, 1, 1);
    applyStimulus("t3don", 0, 0, 0, 64'h0, 0, 64'h0, 1, 1, 1,        1, 64'h8000_0004, 1, 1, 1, 1);
    applyStimulus("t3aft", 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 1,        0, 64'h0, 0, 0, 0, 0);

    // PC register not ready: hold in PEND, then a late override
    applyStimulus("t4acc", 0, 1, 1, 64'h440, 0, 64'h0, 0, 0, 0,      1, 64'h440, 1, 0, 0, 0);
    applyStimulus("t4pn1", 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 0,        1, 64'h440, 1, 0, 1, 1);
    applyStimulus("t4pnx", 0, 0, 0, 64'h0, 1, 64'h700, 0, 0, 0,      1, 64'h700, 1, 0, 1, 1);
    applyStimulus("t4ext", 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 1,        1, 64'h700, 1, 0, 1, 1);
    applyStimulus("t4aft", 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 1,        0, 64'h0, 0, 0, 0, 0);

    // Simultaneous x and d in IDLE: x wins, d is not replayed
    applyStimulus("t5acc", 0, 1, 1, 64'h300, 1, 64'h200, 0, 0, 1,    1, 64'h200, 1, 0, 0, 0);
    applyStimulus("t5nr1", 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 1,        0, 64'h0, 0, 0, 0, 0);
    applyStimulus("t5nr2", 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 1,        0, 64'h0, 0, 0, 0, 0);

    // Response arriving in the accept cycle is dropped without draining
    applyStimulus("t5bfd", 0, 0, 0, 64'h0, 1, 64'h880, 1, 1, 1,      1, 64'h880, 1, 1, 0, 0);
    applyStimulus("t5baf", 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 1,        0, 64'h0, 0, 0, 0, 0);

    // Reset mid-drain abandons the redirect
    applyStimulus("t6acc", 0, 1, 1, 64'h100, 0, 64'h0, 1, 0, 1,      0, 64'h0, 1, 0, 1, 0);
    applyStimulus("t6dr1", 0, 0, 0, 64'h0, 0, 64'h0, 1, 0, 1,        0, 64'h0, 1, 0, 1, 1);
    applyStimulus("t6rst", 1, 0, 0, 64'h0, 0, 64'h0, 1, 1, 1,        0, 64'h0, 0, 0, 0, 0);
    applyStimulus("t6fd",  0, 0, 0, 64'h0, 0, 64'h0, 0, 1, 1,        0, 64'h0, 0, 0, 0, 0);
    applyStimulus("t6end", 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 1,        0, 64'h0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/redirect_ctrl.md
Name: redirect_ctrl

Overview:
- Sequences PC redirects from the decode-stage branch/jump resolver and from a late-stage trap/return source into the fetch stage.
- Owns the wrong-path cleanup:
  - squashes the IF/ID register;
  - waits out and discards an in-flight instruction-bus fetch;
  - holds the redirect until the PC register accepts it.
- Sits between decode (branch resolution), the late stage (trap/mret) and the PC mux/fetch unit. Carries two performance counters.

Parameters:
CNT_W, 32, width of the performance counters redirect_cnt and drop_cnt

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
d_redirect  in  1  decode requests redirect (branch mispredict-to-fallthrough/taken, jal/jalr, fence restart)
d_target  in  64  decode redirect target
d_fire  in  1  decode stage advances this cycle (valid and not stalled)
x_redirect  in  1  late-stage redirect (trap, mret); higher priority than decode
x_target  in  64  late-stage redirect target
f_busy  in  1  fetch has an ibus request outstanding (addr sent, data_ok not yet seen)
f_done  in  1  ibus data_ok this cycle
pc_ready  in  1  PC register loads this cycle if pc_sel is asserted
pc_sel  out  1  PC mux selects pc_target
pc_target  out  64  redirect address
flush_f  out  1  squash IF/ID register contents this cycle
drop_resp  out  1  discard the f_done data this cycle
stall_f  out  1  fetch must not issue a new ibus request
busy  out  1  state != IDLE
redirect_cnt  out  CNT_W  number of redirects applied (pc_sel and pc_ready)
drop_cnt  out  CNT_W  number of fetch responses discarded

Behaviour:
- Accept condition (any state): acc = x_redirect | (d_redirect & d_fire & state==IDLE).
  - Selected target: x_target if x_redirect, else d_target.
  - d_redirect outside IDLE is ignored, because decode holds squashed bubbles then.
- State register and target register tgt (64) update on the rising edge.
- While reset=1: state→IDLE, tgt→0, both counters→0, all outputs driven 0 combinationally.
- Reset mid-DRAIN or mid-PEND abandons the redirect. No pc_sel is issued after reset.
- States: IDLE, DRAIN, PEND.
- IDLE, no acc: all outputs 0.
- IDLE, acc: flush_f=1, and in the same cycle:
  - f_busy=1 and f_done=0: tgt←target; →DRAIN; stall_f=1; pc_sel=0.
  - Otherwise: drop_resp=f_done; pc_sel=1; pc_target=target (zero-latency pass-through).
    - pc_ready=1: stay IDLE.
    - pc_ready=0: tgt←target; →PEND.
- DRAIN:
  - Every cycle: stall_f=1, flush_f=1.
  - x_redirect: tgt←x_target (newest wins). The effective target for this cycle is x_target.
  - f_done=1: drop_resp=1; pc_sel=1; pc_target=effective target. Then pc_ready=1 →IDLE, else →PEND.
  - f_done=0: remain in DRAIN, pc_sel=0.
- PEND:
  - Every cycle: pc_sel=1, flush_f=1, stall_f=1.
  - pc_target = x_target if x_redirect (tgt←x_target), else tgt.
  - pc_ready=1: →IDLE.
- Fetch contract: no new ibus request while stall_f=1. Therefore f_busy=0 in PEND.
  - f_done while in PEND is illegal (assertion).
- Counters:
  - redirect_cnt += 1 on every cycle with pc_sel & pc_ready.
  - drop_cnt += 1 on every cycle with drop_resp.
  - Both wrap modulo 2^CNT_W.
- busy is registered-state derived (state!=IDLE), with no combinational path from inputs.
- pc_target is 0 whenever pc_sel=0.
- Simultaneous x_redirect and d_redirect&d_fire in IDLE: x wins. The decode redirect is dropped (the late stage kills it).

Decomposition:
- Shared pipes package:
  - enum redirect_state_t {IDLE, DRAIN, PEND};
  - struct redirect_t {u1 valid; u64 target;}, used for both the d and x request bundles.
- u1/u64 come from common.
- One sub-module is natural: redirect_arb, the combinational x-over-d priority select producing redirect_t.
- Counters and FSM stay in redirect_ctrl.

Test Plan:
1. IDLE, d_redirect=1, d_fire=1, d_target=0x8000_0040, f_busy=0, pc_ready=1 → same cycle pc_sel=1, pc_target=0x8000_0040, flush_f=1. Next cycle busy=0, redirect_cnt=1.
2. d redirect to 0x100 with f_busy=1, f_done=0, then f_done=1 after 3 cycles, pc_ready=1 →
   - DRAIN for 3 cycles with stall_f=flush_f=1, pc_sel=0;
   - f_done cycle: drop_resp=1, pc_sel=1, pc_target=0x100;
   - drop_cnt=1, back to IDLE.
3. In DRAIN (tgt=0x100), x_redirect=1, x_target=0x8000_0004 one cycle before f_done → the f_done cycle outputs pc_target=0x8000_0004.
4. Accept with f_busy=0, pc_ready=0 for 2 cycles → PEND. pc_sel=1, pc_target held at the same value for 2 cycles; exits on pc_ready=1; redirect_cnt increments once.
5. Same cycle in IDLE: x_target=0x200 and d_target=0x300, both valid → pc_target=0x200. The d request is not replayed later.
6. Assert reset for 1 cycle while in DRAIN → all outputs 0, state IDLE, counters 0. A later f_done produces drop_resp=0 and pc_sel=0.
